uart_xcvr_p: RTL

Parametrised full-duplex UART transceiver. Next generation of the fixed 8-bit, divide-by-16 transmit/receive pair.
- Adds a runtime baud divisor, configurable word length and stop bits, glitch-rejecting start detection, framing-error and break handling, and optional parity.
- Sits between the system bus logic and the serial pins, in the sysclk domain.

---
 rtl/uart_pkg.sv | 42 ++++
 rtl/uart_xcvr_p_if.sv | 39 +++
 rtl/uart_baud_gen.sv | 38 +++
 rtl/uart_xcvr_p.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared types and helpers for the uart_xcvr_p transceiver:
//            TX/RX state encodings, parity-mode codes and the parity helper.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_BREAK  = 3'd5
    } rx_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Widest supported data word; narrower words are zero-extended,
    // which leaves the XOR unchanged.
    localparam int MAX_DATA_W = 9;

    // Even parity is the XOR of the data bits, odd parity its inverse.
    function automatic logic par_bit(input logic [MAX_DATA_W-1:0] d,
                                     input logic                  odd);
        return (^d) ^ odd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_xcvr_p_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_xcvr_p_if
// Purpose  : Bus/pin bundle of the uart_xcvr_p transceiver.
//   slave  (transceiver side): consumes config, TX request and RX pin,
//                              produces status, TX pin and RX word/flags.
//   master (system side)     : the mirror image.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_xcvr_p_if #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) ();
    logic [DIV_W-1:0]  baudDivH;
    logic [1:0]        parModeH;
    logic              xmitH;
    logic [DATA_W-1:0] xmitdataH;
    logic              xmitbusyH;
    logic              xmitdoneH;
    logic              uartXMITdataH;
    logic              uartRECdataH;
    logic [DATA_W-1:0] recdataH;
    logic              recreadyH;
    logic              recerrFrameH;
    logic              recerrParityH;

    modport slave (
        input  baudDivH, parModeH, xmitH, xmitdataH, uartRECdataH,
        output xmitbusyH, xmitdoneH, uartXMITdataH,
               recdataH, recreadyH, recerrFrameH, recerrParityH
    );

    modport master (
        output baudDivH, parModeH, xmitH, xmitdataH, uartRECdataH,
        input  xmitbusyH, xmitdoneH, uartXMITdataH,
               recdataH, recreadyH, recerrFrameH, recerrParityH
    );
endinterface
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_gen
// Purpose  : Runtime-programmable baud tick generator shared by TX and RX.
//   clk    in  system clock
//   rst    in  synchronous active-high reset
//   i_div  in  clock cycles per tick (0 behaves as 1)
//   o_tick out one-cycle tick on counter wrap
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [DIV_W-1:0] i_div,
    output logic                  o_tick
);
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_div_eff;
    logic             w_tick;

    assign w_div_eff = (i_div == '0) ? DIV_W'(1) : i_div;
    // >= so that lowering the divisor mid-count wraps immediately.
    assign w_tick    = (r_cnt >= (w_div_eff - DIV_W'(1)));
    assign o_tick    = w_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/uart_xcvr_p.sv
`default_nettype none
// ============================================================================
// Module   : uart_xcvr_p
// Purpose  : Full-duplex UART transceiver with runtime baud divisor,
//            configurable word length / stop bits, glitch-rejecting start
//            detection, framing-error and break handling, optional parity.
//   sysclk  in  system clock
//   sysrstH in  synchronous active-high reset
//   bus     uart_xcvr_p_if.slave: config, TX request/status, serial pins,
//           received word and error flags
// Build option: UART_PARITY_EN - when defined, parModeH is honoured and the
//           PARITY states/parity error flag are active.
// Revision : 1.0 - initial release
// ============================================================================
module uart_xcvr_p
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16,
    parameter int STOP_BITS  = 1
) (
    input  wire logic      sysclk,
    input  wire logic      sysrstH,
    uart_xcvr_p_if.slave   bus
);
    localparam int             c_tw        = $clog2(OVERSAMPLE);
    localparam logic [c_tw-1:0] c_cell_last = c_tw'(OVERSAMPLE - 1);
    localparam logic [c_tw-1:0] c_half_last = c_tw'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]      c_data_last = 4'(DATA_W - 1);
    localparam logic [3:0]      c_stop_last = 4'(STOP_BITS - 1);

    logic w_tick;

    uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
        .clk    (sysclk),
        .rst    (sysrstH),
        .i_div  (bus.baudDivH),
        .o_tick (w_tick)
    );

    // ------------------------------------------------------------------ parity
    logic w_par_on;
    logic w_par_odd;
`ifdef UART_PARITY_EN
    assign w_par_on  = (bus.parModeH == PAR_EVEN) || (bus.parModeH == PAR_ODD);
    assign w_par_odd = (bus.parModeH == PAR_ODD);
`else
    logic w_unused_par;
    assign w_unused_par = ^bus.parModeH;
    assign w_par_on     = 1'b0;
    assign w_par_odd    = 1'b0;
`endif

    // ---------------------------------------------------------------------- TX
    tx_state_t          r_tx_state, w_tx_next;
    logic [c_tw-1:0]    r_tx_tcnt;
    logic [3:0]         r_tx_bcnt;
    logic [DATA_W-1:0]  r_tx_data;   // shifts right, bit 0 is on the line
    logic               r_tx_xor;    // XOR of the accepted word
    logic               r_tx_done;
    logic               w_tx_cell_end;
    logic               w_tx_line;
    logic               w_tx_busy;

    assign w_tx_cell_end = w_tick && (r_tx_tcnt == c_cell_last);

    always_ff @(posedge sysclk) begin
        if (sysrstH) r_tx_state <= TX_IDLE;
        else         r_tx_state <= w_tx_next;
    end

    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            TX_IDLE:   if (bus.xmitH) w_tx_next = TX_START;
            TX_START:  if (w_tx_cell_end) w_tx_next = TX_DATA;
            TX_DATA:   if (w_tx_cell_end && r_tx_bcnt == c_data_last)
                           w_tx_next = w_par_on ? TX_PARITY : TX_STOP;
            TX_PARITY: if (w_tx_cell_end) w_tx_next = TX_STOP;
            // A request pending at the end of the last stop cell is
            // accepted directly, giving back-to-back frames.
            TX_STOP:   if (w_tx_cell_end && r_tx_bcnt == c_stop_last)
                           w_tx_next = bus.xmitH ? TX_START : TX_IDLE;
            default:   w_tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        w_tx_line = 1'b1;
        w_tx_busy = (r_tx_state != TX_IDLE);
        case (r_tx_state)
            TX_START:  w_tx_line = 1'b0;
            TX_DATA:   w_tx_line = r_tx_data[0];
            TX_PARITY: w_tx_line = r_tx_xor ^ w_par_odd;
            default:   w_tx_line = 1'b1;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (sysrstH) begin
            r_tx_tcnt <= '0;
            r_tx_bcnt <= '0;
            r_tx_data <= '0;
            r_tx_xor  <= 1'b0;
            r_tx_done <= 1'b0;
        end else begin
            r_tx_done <= (r_tx_state == TX_STOP) && (w_tx_next != TX_STOP);

            if (r_tx_state == TX_IDLE)
                r_tx_tcnt <= '0;
            else if (w_tick)
                r_tx_tcnt <= w_tx_cell_end ? '0 : r_tx_tcnt + c_tw'(1);

            if (w_tx_next != r_tx_state)
                r_tx_bcnt <= '0;
            else if (w_tx_cell_end)
                r_tx_bcnt <= r_tx_bcnt + 4'd1;

            if (w_tx_next == TX_START && r_tx_state != TX_START) begin
                r_tx_data <= bus.xmitdataH;
                r_tx_xor  <= par_bit(MAX_DATA_W'(bus.xmitdataH), 1'b0);
            end else if (r_tx_state == TX_DATA && w_tx_cell_end) begin
                r_tx_data <= r_tx_data >> 1;
            end
        end
    end

    assign bus.uartXMITdataH = w_tx_line;
    assign bus.xmitbusyH     = w_tx_busy;
    assign bus.xmitdoneH     = r_tx_done;

    // ---------------------------------------------------------------------- RX
    rx_state_t          r_rx_state, w_rx_next;
    logic               r_rx_s1, r_rx_s2, r_rx_s3;
    logic [c_tw-1:0]    r_rx_tcnt;
    logic [3:0]         r_rx_bcnt;
    logic [DATA_W-1:0]  r_rx_shift;
    logic [DATA_W-1:0]  r_rx_data;
    logic               r_rx_ready;
    logic               r_rx_ferr;
    logic               w_rx_fall;
    logic               w_rx_samp;

    assign w_rx_fall = r_rx_s3 & ~r_rx_s2;
    // START samples at mid-cell; every later sample is one full cell on.
    assign w_rx_samp = w_tick && ((r_rx_state == RX_START) ?
                                  (r_rx_tcnt == c_half_last) :
                                  (r_rx_tcnt == c_cell_last));

    always_ff @(posedge sysclk) begin
        if (sysrstH) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_s3 <= 1'b1;
        end else begin
            r_rx_s1 <= bus.uartRECdataH;
            r_rx_s2 <= r_rx_s1;
            r_rx_s3 <= r_rx_s2;
        end
    end

    always_ff @(posedge sysclk) begin
        if (sysrstH) r_rx_state <= RX_IDLE;
        else         r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE:   if (w_rx_fall) w_rx_next = RX_START;
            RX_START:  if (w_rx_samp) w_rx_next = r_rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:   if (w_rx_samp && r_rx_bcnt == c_data_last)
                           w_rx_next = w_par_on ? RX_PARITY : RX_STOP;
            RX_PARITY: if (w_rx_samp) w_rx_next = RX_STOP;
            // Leaving at the stop centre re-arms half a cell early; an
            // all-zero word with a low stop bit is a break condition.
            RX_STOP:   if (w_rx_samp)
                           w_rx_next = (!r_rx_s2 && r_rx_shift == '0) ?
                                       RX_BREAK : RX_IDLE;
            RX_BREAK:  if (r_rx_s2) w_rx_next = RX_IDLE;
            default:   w_rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (sysrstH) begin
            r_rx_tcnt  <= '0;
            r_rx_bcnt  <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_ready <= 1'b0;
            r_rx_ferr  <= 1'b0;
        end else begin
            if (r_rx_state == RX_IDLE || r_rx_state == RX_BREAK)
                r_rx_tcnt <= '0;
            else if (w_tick)
                r_rx_tcnt <= w_rx_samp ? '0 : r_rx_tcnt + c_tw'(1);

            if (w_rx_next != r_rx_state)
                r_rx_bcnt <= '0;
            else if (w_rx_samp)
                r_rx_bcnt <= r_rx_bcnt + 4'd1;

            if (r_rx_state == RX_DATA && w_rx_samp)
                r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_W-1:1]};

            r_rx_ready <= (r_rx_state == RX_STOP) && w_rx_samp;
            r_rx_ferr  <= (r_rx_state == RX_STOP) && w_rx_samp && !r_rx_s2;
            if (r_rx_state == RX_STOP && w_rx_samp)
                r_rx_data <= r_rx_shift;
        end
    end

`ifdef UART_PARITY_EN
    logic r_rx_pbit;
    logic r_rx_perr;

    always_ff @(posedge sysclk) begin
        if (sysrstH) begin
            r_rx_pbit <= 1'b0;
            r_rx_perr <= 1'b0;
        end else begin
            if (r_rx_state == RX_PARITY && w_rx_samp)
                r_rx_pbit <= r_rx_s2;
            r_rx_perr <= (r_rx_state == RX_STOP) && w_rx_samp && w_par_on &&
                         (r_rx_pbit != par_bit(MAX_DATA_W'(r_rx_shift), w_par_odd));
        end
    end

    assign bus.recerrParityH = r_rx_perr;
`else
    assign bus.recerrParityH = 1'b0;
`endif

    assign bus.recdataH     = r_rx_data;
    assign bus.recreadyH    = r_rx_ready;
    assign bus.recerrFrameH = r_rx_ferr;
endmodule
`default_nettype wire
